rgbw_wrd2sout: RTL

RGBW_WRD2SOUT -- requirements
Module: rgbw_wrd2sout

---
 rtl/rgbw_wrd2sout.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/rgbw_wrd2sout.sv
// rgbw_wrd2sout: pulls 32-bit pixel words from an upstream FIFO, optionally
// extracts a white channel from RGB, and serialises {G,R,B,W} MSB first as
// SK6812-style pulse-width coded bits. Stream-reset words (and the first
// cycle out of reset) hold the line low long enough for the strip to latch.
module rgbw_wrd2sout #(
    parameter int T0H_CLKS      = 29,
    parameter int T1H_CLKS      = 58,
    parameter int TBIT_CLKS     = 120,
    parameter int TRESET_CLKS   = 7680,
    parameter bit WHITE_EXTRACT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_fifo_empty,
    input  logic [31:0] in_fifo_word,
    output logic        out_fifo_rd,
    output logic        out_serial,
    output logic        out_busy
);

    // One counter serves every timed phase, so it is sized for the longest one.
    localparam int CNT_MAX = (TRESET_CLKS > TBIT_CLKS) ? TRESET_CLKS : TBIT_CLKS;
    localparam int CW      = $clog2(CNT_MAX + 1);

    // Counter load values: a phase of N cycles loads N-1 and ends at zero.
    localparam logic [CW-1:0] T0H_LD  = CW'(T0H_CLKS - 1);
    localparam logic [CW-1:0] T1H_LD  = CW'(T1H_CLKS - 1);
    localparam logic [CW-1:0] T0L_LD  = CW'(TBIT_CLKS - T0H_CLKS - 1);
    localparam logic [CW-1:0] T1L_LD  = CW'(TBIT_CLKS - T1H_CLKS - 1);
    localparam logic [CW-1:0] TRST_LD = CW'(TRESET_CLKS - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [2:0] {
        RESET_LOW = 3'd0,
        IDLE      = 3'd1,
        FETCH     = 3'd2,
        LOAD      = 3'd3,
        CONVERT   = 3'd4,
        SEND_HIGH = 3'd5,
        SEND_LOW  = 3'd6
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic [4:0]      bit_idx_r;
    logic [31:0]     shreg_r;
    logic            word_valid_r;
    logic            word_srst_r;
    logic [23:0]     pix_r;
    logic            rst_pend_r;
    logic [31:0]     conv_s;
    logic            unused_bits_s;

    // Bits 29:24 of the FIFO word carry no meaning for this block.
    assign unused_bits_s = ^in_fifo_word[29:24];

    // Smallest of three 8-bit channel values.
    function automatic logic [7:0] min3(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        logic [7:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    // Build the 32-bit transmit word {G', R', B', W} from a {G, R, B} pixel.
    function automatic logic [31:0] convert_word(input logic [23:0] pix);
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
        logic [7:0] w;
        g = pix[23:16];
        r = pix[15:8];
        b = pix[7:0];
        if (WHITE_EXTRACT) begin
            // W is the common minimum, so none of these subtractions can underflow.
            w = min3(r, g, b);
            return {g - w, r - w, b - w, w};
        end else begin
            return {g, r, b, 8'h00};
        end
    endfunction

    // Conversion of the captured pixel, consumed in CONVERT.
    always_comb begin
        conv_s = convert_word(pix_r);
    end

    // Main FSM: sequencing, bit timing, FIFO handshake and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            bit_idx_r    <= 5'd0;
            shreg_r      <= 32'h0000_0000;
            word_valid_r <= 1'b0;
            word_srst_r  <= 1'b0;
            pix_r        <= 24'h00_0000;
            rst_pend_r   <= 1'b1;
            out_fifo_rd  <= 1'b0;
            out_serial   <= 1'b0;
            out_busy     <= 1'b0;
        end else if (rst_pend_r) begin
            // Leaving reset: latch the strip before any pixel can be sent.
            rst_pend_r  <= 1'b0;
            state_r     <= RESET_LOW;
            cnt_r       <= TRST_LD;
            out_fifo_rd <= 1'b0;
            out_serial  <= 1'b0;
            out_busy    <= 1'b1;
        end else begin
            out_fifo_rd <= 1'b0;
            case (state_r)
                RESET_LOW: begin
                    if (cnt_r == '0) begin
                        state_r  <= IDLE;
                        out_busy <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                IDLE: begin
                    if (!in_fifo_empty) begin
                        state_r     <= FETCH;
                        out_fifo_rd <= 1'b1;
                        out_busy    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FETCH: begin
                    state_r <= LOAD;
                end
                LOAD: begin
                    // Read data is valid now, one cycle after the read pulse.
                    word_valid_r <= in_fifo_word[31];
                    word_srst_r  <= in_fifo_word[30];
                    pix_r        <= in_fifo_word[23:0];
                    state_r      <= CONVERT;
                end
                CONVERT: begin
                    if (!word_valid_r) begin
                        state_r  <= IDLE;
                        out_busy <= 1'b0;
                    end else if (word_srst_r) begin
                        state_r    <= RESET_LOW;
                        cnt_r      <= TRST_LD;
                        out_serial <= 1'b0;
                    end else begin
                        shreg_r    <= conv_s;
                        bit_idx_r  <= 5'd0;
                        out_serial <= 1'b1;
                        cnt_r      <= conv_s[31] ? T1H_LD : T0H_LD;
                        state_r    <= SEND_HIGH;
                    end
                end
                SEND_HIGH: begin
                    if (cnt_r == '0) begin
                        out_serial <= 1'b0;
                        cnt_r      <= shreg_r[31] ? T1L_LD : T0L_LD;
                        state_r    <= SEND_LOW;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                SEND_LOW: begin
                    if (cnt_r == '0) begin
                        if (bit_idx_r == 5'd31) begin
                            state_r  <= IDLE;
                            out_busy <= 1'b0;
                        end else begin
                            // Next bit is shreg_r[30] before the shift takes effect.
                            bit_idx_r  <= bit_idx_r + 5'd1;
                            shreg_r    <= {shreg_r[30:0], 1'b0};
                            out_serial <= 1'b1;
                            cnt_r      <= shreg_r[30] ? T1H_LD : T0H_LD;
                            state_r    <= SEND_HIGH;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    out_serial <= 1'b0;
                    out_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
